seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
// Multiplexed N-digit 7-segment display driver; successor to the single-digit hex decoder.
// - Scans DIGITS digits by time-division and decodes each 4-bit nibble with the 0..F table.
// - Adds a double-buffered load, per-digit decimal point and blanking, leading-zero suppression,
//   16-level brightness PWM and selectable output polarity.
// - Sits between the piano note/score logic and the board segment/digit pins.
// PARAMETERS
// DIGITS        4      number of multiplexed digits (1..8)
// SCAN_DIV      50000  clocks per digit slot (>=16)
// SEG_ACT_LOW   0      1: seg_out active-low (common anode)
// DIG_ACT_LOW   1      1: dig_sel active-low
// PORTS
// clk         in   1          system clock
// rst         in   1          asynchronous, active-high reset
// load        in   1          1-cycle strobe: capture data/dp_mask/blank_mask into pending buffer
// data        in   4*DIGITS   nibble i = data[4i+3:4i]; digit 0 = rightmost/least significant
// dp_mask     in   DIGITS     1 = decimal point lit on digit i
// blank_mask  in   DIGITS     1 = digit i forced dark (dp too)
// lz_en       in   1          leading-zero suppression enable (sampled live)
// bright      in   4          brightness, on-time = (bright+1)/16 of each slot (sampled live)
// seg_out     out  8          {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
// dig_sel     out  DIGITS     one-hot digit enable, polarity per DIG_ACT_LOW
// frame_done  out  1          1-cycle pulse at each frame boundary
// BEHAVIOUR
// - Reset (async): slot counter cnt=0, index idx=0, active and pending buffers=0,
//   pend_vld=0, frame_done=0, seg_out and dig_sel all at inactive level.
// - cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances idx+1, wrapping DIGITS-1 -> 0.
// - Frame boundary = the cycle with cnt==SCAN_DIV-1 and idx==DIGITS-1.
// - load: pending <= {data,dp_mask,blank_mask} and pend_vld <= 1. A later load before the
//   boundary overwrites pending.
// - At a frame boundary with pend_vld=1: active <= pending and pend_vld <= 0.
//   frame_done pulses on every boundary regardless of pend_vld.
// - Load on the boundary cycle: the transfer uses pre-edge pending; the new values land in
//   pending with pend_vld=1 and display one frame later. No torn frames ever.
// - Decode table, bits g..a: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
//   A:77 b:7C C:39 d:5E E:79 F:71. dp = bit 7.
// - Suppression: digit i (i>=1) is dark when lz_en=1 and the active nibbles DIGITS-1..i are
//   all zero. Digit 0 is never suppressed, so all-zero data shows "0".
// - A dark digit (blank_mask, suppressed, or PWM off) drives all seg bits inactive, dp included.
//   Its dig_sel bit still scans.
// - PWM: digit on when cnt*16 < (bright+1)*SCAN_DIV, using unsigned math widened to avoid
//   overflow. bright=15 gives full on-time.
//   When off, dig_sel is all inactive and seg_out is all inactive.
// - Outputs are registered, 1-cycle latency from (cnt,idx). dig_sel has exactly one active bit
//   when on and none when off.
// - Polarity: the active level of each output bit is inverted when the matching parameter is 1.
// - lz_en and bright may change at any time; the change takes effect on the next clock.
// - Reset mid-frame returns to reset state immediately. Pending data is lost, and the display
//   stays dark until the first load and frame boundary.
// TESTING
// Use DIGITS=4, SCAN_DIV=16, SEG_ACT_LOW=0, DIG_ACT_LOW=1, bright=15 unless noted.
// - Reset then idle:
//   -> seg_out=00 and dig_sel=4'hF at all times; frame_done pulses every 64 clocks.
// - load data=16'h12AF, masks 0:
//   -> after the next boundary, slots show F:71 (dig_sel=E), A:77 (D), 2:5B (B), 1:06 (7).
// - Leading zeros, data=16'h0050, lz_en=1:
//   -> digits 3,2 seg=00, digit1=6D, digit0=3F. With data=0000, only digit0=3F.
// - Same-cycle load: load 16'h1111 mid-frame, then 16'h2222 on the boundary cycle:
//   -> next frame shows 1111, the following frame 2222; no mixed frame.
// - bright=3:
//   -> each 16-clock slot has 4 clocks with a digit on and 12 with dig_sel=F, seg=00.
//   With dp_mask=0001, digit 0 seg bit7=1. With blank_mask=0010, digit 1 seg=00.
// - Assert rst mid-slot:
//   -> outputs inactive asynchronously and frame_done=0; after release, the first boundary
//   falls at clock 64.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with double-buffered load, decimal points,
// blanking, leading-zero suppression, 16-level brightness PWM and selectable polarity.
module seg_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned SEG_ACT_LOW = 0,
    parameter int unsigned DIG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    input  logic [3:0]            bright,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = CW + 5;
    localparam int unsigned DW = 4 * DIGITS;

    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [PW-1:0]     DIV_W    = PW'(SCAN_DIV);
    localparam logic [7:0]        SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Slot timing and buffers
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DW-1:0]     pend_data;
    logic [DIGITS-1:0] pend_dp;
    logic [DIGITS-1:0] pend_blank;
    logic              pend_vld;
    logic [DW-1:0]     act_data;
    logic [DIGITS-1:0] act_dp;
    logic [DIGITS-1:0] act_blank;
    logic              act_vld;

    // Combinational next values
    logic              boundary_c;
    logic [CW-1:0]     cnt_next_c;
    logic [IW-1:0]     idx_next_c;
    logic [PW-1:0]     pwm_lhs_c;
    logic [PW-1:0]     pwm_rhs_c;
    logic              pwm_on_c;
    logic [3:0]        nib_c;
    logic              dp_bit_c;
    logic              blank_bit_c;
    logic              supp_bit_c;
    logic              zero_run_c;
    logic              lit_slot_c;
    logic [7:0]        seg_next_c;
    logic [DIGITS-1:0] dig_next_c;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Slot counter, digit index and frame boundary
    always_comb begin
        boundary_c = (cnt == CNT_LAST) && (idx == IDX_LAST);
        cnt_next_c = cnt + CW'(1);
        idx_next_c = idx;
        if (cnt == CNT_LAST) begin
            cnt_next_c = '0;
            idx_next_c = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // Brightness: on while cnt*16 < (bright+1)*SCAN_DIV, computed wide enough not to wrap
    always_comb begin
        pwm_lhs_c = PW'(cnt) << 4;
        pwm_rhs_c = (PW'(bright) + PW'(1)) * DIV_W;
        pwm_on_c  = pwm_lhs_c < pwm_rhs_c;
    end

    // Current-digit fields and leading-zero run scanned from the most significant digit down
    always_comb begin
        nib_c       = 4'h0;
        dp_bit_c    = 1'b0;
        blank_bit_c = 1'b0;
        supp_bit_c  = 1'b0;
        zero_run_c  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c & (act_data[4*i +: 4] == 4'h0);
            if (IW'(i) == idx) begin
                nib_c       = act_data[4*i +: 4];
                dp_bit_c    = act_dp[i];
                blank_bit_c = act_blank[i];
                supp_bit_c  = lz_en & zero_run_c & (i != 0);
            end
        end
    end

    // Segment and digit patterns in active-high form
    always_comb begin
        lit_slot_c = act_vld & pwm_on_c;
        seg_next_c = 8'h00;
        dig_next_c = '0;
        if (lit_slot_c) begin
            dig_next_c = DIGITS'(1) << idx;
            if (!blank_bit_c && !supp_bit_c) begin
                seg_next_c = {dp_bit_c, dec7(nib_c)};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next_c;
            idx <= idx_next_c;
        end
    end

    // Double buffer: a load on the boundary cycle lands in pending after the transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_vld   <= 1'b0;
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_vld    <= 1'b0;
        end else begin
            if (boundary_c && pend_vld) begin
                act_data  <= pend_data;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
                act_vld   <= 1'b1;
            end
            if (load) begin
                pend_data  <= data;
                pend_dp    <= dp_mask;
                pend_blank <= blank_mask;
                pend_vld   <= 1'b1;
            end else if (boundary_c) begin
                pend_vld   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out    <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next_c ^ SEG_OFF;
            dig_sel    <= dig_next_c ^ DIG_OFF;
            frame_done <= boundary_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: table of display vectors plus hand-written
// sequences for reset timing, boundary-cycle load and mid-slot reset.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  bright;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int n_chk;
    int n_fail;

    seg_scan_driver #(
        .DIGITS(4), .SCAN_DIV(16), .SEG_ACT_LOW(0), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .lz_en(lz_en), .bright(bright),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [3:0]  bright;
        logic [31:0] segs;    // {digit3, digit2, digit1, digit0}
        int          on_cnt;  // lit clocks per frame
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 200);
        if (!frame_done) chk({name, "_timeout"}, 32'(k), 32'd64);
    endtask

    // From a frame_done sample point, step one full frame and check each slot
    task automatic run_frame(input string name, input logic [31:0] segs, input int on_cnt);
        logic [3:0] exp_dig [4];
        logic [7:0] exp_seg;
        int on, bad, d, c;
        exp_dig[0] = 4'hE; exp_dig[1] = 4'hD; exp_dig[2] = 4'hB; exp_dig[3] = 4'h7;
        on = 0;
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            d = (k - 1) / 16;
            c = (k - 1) % 16;
            if (c == 0) begin
                exp_seg = segs[8*d +: 8];
                chk($sformatf("%s_seg%0d", name, d), 32'(seg_out), 32'(exp_seg));
                chk($sformatf("%s_dig%0d", name, d), 32'(dig_sel), 32'(exp_dig[d]));
            end
            if (dig_sel != 4'hF) begin
                on++;
                if (dig_sel != exp_dig[d]) bad++;
            end else if (seg_out != 8'h00) begin
                bad++;
            end
            if ((dig_sel != 4'hF) != (c < on_cnt / 4)) bad++;
            if (k < 64 && frame_done) bad++;
        end
        chk({name, "_on_cnt"}, 32'(on), 32'(on_cnt));
        chk({name, "_slot_bad"}, 32'(bad), 32'd0);
        chk({name, "_frame_done"}, 32'(frame_done), 32'd1);
    endtask

    // Count clocks to the next frame_done while requiring a dark display
    task automatic count_dark(output int k, output int bad);
        k = 0;
        bad = 0;
        do begin
            @(negedge clk);
            k++;
            if (dig_sel != 4'hF || seg_out != 8'h00) bad++;
        end while (!frame_done && k < 200);
    endtask

    vec_t vecs [8];
    int   k, bad;

    initial begin
        n_chk = 0;
        n_fail = 0;
        vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15, 32'h065B_7771, 64};
        vecs[1] = '{16'h0050, 4'h0, 4'h0, 1'b1, 4'd15, 32'h0000_6D3F, 64};
        vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'd15, 32'h0000_003F, 64};
        vecs[3] = '{16'h0000, 4'h0, 4'h0, 1'b0, 4'd15, 32'h3F3F_3F3F, 64};
        vecs[4] = '{16'h12AF, 4'h1, 4'h2, 1'b0, 4'd3,  32'h065B_00F1, 16};
        vecs[5] = '{16'h89CE, 4'hA, 4'h0, 1'b0, 4'd7,  32'hFF6F_B979, 32};
        vecs[6] = '{16'h3456, 4'h8, 4'h8, 1'b1, 4'd15, 32'h0066_6D7D, 64};
        vecs[7] = '{16'h0B0D, 4'h0, 4'h0, 1'b1, 4'd0,  32'h007C_3F5E, 4};

        rst = 1'b1; load = 1'b0; data = '0; dp_mask = '0; blank_mask = '0;
        lz_en = 1'b0; bright = 4'd15;
        #1;
        chk("rst_seg", 32'(seg_out), 32'h00);
        chk("rst_dig", 32'(dig_sel), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'd0);

        // Idle after reset: dark, boundaries every 64 clocks
        @(negedge clk);
        rst = 1'b0;
        count_dark(k, bad);
        chk("idle_first_fd", 32'(k), 32'd64);
        chk("idle_dark1", 32'(bad), 32'd0);
        count_dark(k, bad);
        chk("idle_period", 32'(k), 32'd64);
        chk("idle_dark2", 32'(bad), 32'd0);

        for (int v = 0; v < 8; v++) begin
            data = vecs[v].data; dp_mask = vecs[v].dp; blank_mask = vecs[v].blank;
            lz_en = vecs[v].lz; bright = vecs[v].bright;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame($sformatf("v%0d", v));
            run_frame($sformatf("v%0d", v), vecs[v].segs, vecs[v].on_cnt);
        end

        // Load mid-frame then again on the boundary cycle: no mixed frame
        dp_mask = '0; blank_mask = '0; lz_en = 1'b0; bright = 4'd15;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (j == 20) begin data = 16'h1111; load = 1'b1; end
            if (j == 63) begin data = 16'h2222; load = 1'b1; end
        end
        chk("same_cyc_fd", 32'(frame_done), 32'd1);
        run_frame("same_cyc_1111", 32'h0606_0606, 64);
        run_frame("same_cyc_2222", 32'h5B5B_5B5B, 64);

        // Mid-slot reset with a pending load: outputs drop at once, pending is lost
        data = 16'h7777; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_dig", 32'(dig_sel), 32'hE);
        chk("pre_rst_seg", 32'(seg_out), 32'h5B);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seg_out), 32'h00);
        chk("async_rst_dig", 32'(dig_sel), 32'hF);
        chk("async_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_dark(k, bad);
        chk("rst2_first_fd", 32'(k), 32'd64);
        chk("rst2_dark1", 32'(bad), 32'd0);
        count_dark(k, bad);
        chk("rst2_period", 32'(k), 32'd64);
        chk("rst2_dark2", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
